// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional even-parity support is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam int unsigned DEF_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: pulses bit_done_c on the last clk of each bit period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic bit_done_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_done_c = en && (cnt == CW'(CLKS_PER_BIT - 1));

  // Divider counter, restarted on every bit boundary and on frame acceptance
  always_ff @(posedge clk) begin
    if (nrst || clr) begin
      cnt <= '0;
    end else if (bit_done_c) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 q,
  output logic                 ready
);

  localparam int unsigned BW = $clog2(DATA_BITS);

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic                 stopcnt, stopcnt_n;
  logic                 q_n, ready_n;
  logic                 accept_c;
  logic                 bit_done_c;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk        (clk),
    .nrst       (nrst),
    .clr        (accept_c),
    .en         (state != IDLE),
    .bit_done_c (bit_done_c)
  );

  // State and registered line outputs
  always_ff @(posedge clk) begin
    if (nrst) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      q       <= LINE_IDLE;
      ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bitcnt  <= bitcnt_n;
      stopcnt <= stopcnt_n;
      q       <= q_n;
      ready   <= ready_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // Next-state, shift and next line level; q/ready are derived from the next state
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    stopcnt_n = stopcnt;
    accept_c  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n     = par;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          shreg_n   = data;
          bitcnt_n  = '0;
          stopcnt_n = 1'b0;
          state_n   = START;
`ifdef UART_TX_PARITY_EN
          par_n     = ^data;
`endif
        end
      end
      START: begin
        if (bit_done_c) state_n = DATA;
      end
      DATA: begin
        if (bit_done_c) begin
          shreg_n = shreg >> 1;
          if (bitcnt == BW'(DATA_BITS - 1)) begin
            bitcnt_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n  = PARITY;
`else
            state_n  = STOP;
`endif
          end else begin
            bitcnt_n = bitcnt + BW'(1);
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_done_c) state_n = STOP;
`else
        state_n = IDLE;
`endif
      end
      STOP: begin
        if (bit_done_c) begin
          if (stopcnt == 1'(STOP_BITS - 1)) begin
            stopcnt_n = 1'b0;
            state_n   = IDLE;
          end else begin
            stopcnt_n = stopcnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   q_n = START_BIT;
      DATA:    q_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  q_n = par_n;
`endif
      default: q_n = LINE_IDLE;
    endcase

    ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed bench for uart_tx against a frame-level reference model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic [7:0] data1 = 8'h00, data4 = 8'h00;
  logic       q1, rdy1, q4, rdy4;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .nrst(nrst), .start(start1), .data(data1), .q(q1), .ready(rdy1)
  );

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
    .clk(clk), .nrst(nrst), .start(start4), .data(data4), .q(q4), .ready(rdy4)
  );

`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  int   total = 0;
  int   bad   = 0;
  logic exp1[$];
  logic exp4[$];
  bit   cur_rdy1 = 1'b1;
  bit   cur_rdy4 = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit i of the result is the i-th bit period of the frame on the line
  function automatic logic [15:0] frame_vec(input logic [7:0] d);
    logic [15:0] v;
    v      = '0;
    v[0]   = 1'b0;
    v[8:1] = d;
`ifdef UART_TX_PARITY_EN
    v[9]   = ^d;
    v[10]  = 1'b1;
`else
    v[9]   = 1'b1;
`endif
    return v;
  endfunction

  // Advance one clock, update the model, compare both transmitters
  task automatic step();
    bit          acc1, acc4;
    logic [7:0]  d1, d4;
    logic [15:0] v;
    logic        e;
    bit          r;
    acc1 = (start1 === 1'b1) && cur_rdy1 && (nrst === 1'b0);
    acc4 = (start4 === 1'b1) && cur_rdy4 && (nrst === 1'b0);
    d1 = data1;
    d4 = data4;
    @(posedge clk);
    #1;
    if (nrst) begin
      exp1.delete();
      exp4.delete();
    end else begin
      if (acc1) begin
        v = frame_vec(d1);
        for (int b = 0; b < FLEN; b++) exp1.push_back(v[b]);
      end
      if (acc4) begin
        v = frame_vec(d4);
        for (int b = 0; b < FLEN; b++)
          for (int c = 0; c < 4; c++) exp4.push_back(v[b]);
      end
    end
    if (exp1.size() > 0) begin e = exp1.pop_front(); r = 1'b0; end
    else begin e = 1'b1; r = 1'b1; end
    cur_rdy1 = r;
    check("q1", 32'(q1), 32'(e));
    check("ready1", 32'(rdy1), 32'(r));
    if (exp4.size() > 0) begin e = exp4.pop_front(); r = 1'b0; end
    else begin e = 1'b1; r = 1'b1; end
    cur_rdy4 = r;
    check("q4", 32'(q4), 32'(e));
    check("ready4", 32'(rdy4), 32'(r));
  endtask

  // Send one frame on the selected DUT, count busy cycles and capture one sample per bit
  task automatic measure(input bit use4, input logic [7:0] d,
                         output int cnt, output logic [15:0] v);
    bit done;
    int per;
    logic qq, rr;
    done = 1'b0;
    cnt  = 0;
    v    = '0;
    per  = use4 ? 4 : 1;
    if (use4) begin data4 = d; start4 = 1'b1; end
    else      begin data1 = d; start1 = 1'b1; end
    step();
    start1 = 1'b0;
    start4 = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      qq = use4 ? q4 : q1;
      rr = use4 ? rdy4 : rdy1;
      if (rr === 1'b0) begin
        if ((cnt % per) == 0 && (cnt / per) < 16) v[cnt / per] = qq;
        cnt++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    check("frame_done", 32'(done), 32'd1);
  endtask

  int          cnt;
  logic [15:0] v;

  initial begin
    // Reset held for two cycles, then idle line with start low
    nrst = 1'b1;
    step();
    step();
    nrst = 1'b0;
    repeat (4) step();

    // Single 0x5A frame
    measure(1'b0, 8'h5A, cnt, v);
    check("busy_5a", 32'(cnt), 32'(FLEN));
`ifdef UART_TX_PARITY_EN
    check("bits_5a", 32'(v), 32'h04B4);
`else
    check("bits_5a", 32'(v), 32'h02B4);
`endif
    repeat (2) step();

    // Back-to-back frames with start held: 0xFF then 0x00
    start1 = 1'b1;
    data1  = 8'hFF;
    step();
    data1 = 8'h00;
    repeat (2 * FLEN + 2) step();
    start1 = 1'b0;
    repeat (FLEN + 2) step();

    // Data changed after acceptance must not disturb the frame
    start1 = 1'b1;
    data1  = 8'hA5;
    step();
    start1 = 1'b0;
    data1  = 8'h3C;
    repeat (FLEN + 2) step();

    // Reset during data bit 3, then a normal frame
    start1 = 1'b1;
    data1  = 8'h96;
    step();
    start1 = 1'b0;
    repeat (4) step();
    nrst = 1'b1;
    step();
    nrst = 1'b0;
    check("rst_q", 32'(q1), 32'd1);
    check("rst_ready", 32'(rdy1), 32'd1);
    repeat (3) step();
    measure(1'b0, 8'hC3, cnt, v);
    check("busy_after_rst", 32'(cnt), 32'(FLEN));

    // Reset and start together: reset wins
    nrst   = 1'b1;
    start1 = 1'b1;
    start4 = 1'b1;
    step();
    nrst   = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    step();
    check("rst_start_ready", 32'(rdy1), 32'd1);

    // Slow bit clock: 4 clk per bit with 0x01
    measure(1'b1, 8'h01, cnt, v);
    check("busy_cpb4", 32'(cnt), 32'(FLEN * 4));
`ifdef UART_TX_PARITY_EN
    check("bits_cpb4", 32'(v), 32'h0602);
`else
    check("bits_cpb4", 32'(v), 32'h0202);
`endif
    repeat (2) step();

    // Random traffic with occasional resets on both transmitters
    for (int i = 0; i < 400; i++) begin
      start1 = ($urandom_range(0, 3) == 0);
      data1  = 8'($urandom);
      start4 = ($urandom_range(0, 3) == 0);
      data4  = 8'($urandom);
      nrst   = ($urandom_range(0, 79) == 0);
      step();
    end
    nrst   = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    repeat (4 * FLEN + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
